// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, LS) and memory-bus signals around mem_port_arbiter.
// master = arbiter side, slave = requesters plus memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        bus_err;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output bus_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory bus between IF and LS, LS priority with IF starvation bound.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [2:0]  starve_q, starve_d;
  logic        if_gnt_q, if_gnt_d;
  logic        ls_gnt_q, ls_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] ls_rdata_q, ls_rdata_d;
  logic        grant_ls;
  logic        timeout_hit;
  logic        in_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LIM = 8'(TIMEOUT_CYC);

  logic [7:0] wdog_q, wdog_d;
  logic       bus_err_q, bus_err_d;

  // Counter is zero in the first REQ cycle because it idles at zero.
  assign timeout_hit = (state_q != IDLE) && (wdog_q == WDOG_LIM);

  always_comb begin
    wdog_d = (state_q == IDLE) ? 8'd0 : wdog_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      // NOTE: the wide data registers are reset too because they drive visible outputs.
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Next-state and arbitration.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    grant_ls    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    bus_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          grant_ls = bus.ls_req && !(bus.if_req && (starve_q == STARVE_LIM));
          state_d  = REQ;
          if (grant_ls) begin
            owner_d  = OWN_LS;
            addr_d   = bus.ls_addr;
            we_d     = bus.ls_we;
            wdata_d  = bus.ls_wdata;
            wstrb_d  = bus.ls_wstrb;
            ls_gnt_d = 1'b1;
            if (bus.if_req && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + 3'd1;
            end
          end else begin
            owner_d  = OWN_IF;
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            wstrb_d  = '0;
            if_gnt_d = 1'b1;
            starve_d = '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          if (we_q) begin
            state_d     = IDLE;
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = '0;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort overrides any handshake seen in the same cycle.
    if (timeout_hit) begin
      state_d   = IDLE;
      bus_err_d = 1'b1;
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = '0;
      end else begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = '0;
      end
    end
`endif
  end

  // Outputs.
  always_comb begin
    in_req        = (state_q == REQ);
    bus.mem_req   = in_req && !timeout_hit;
    bus.mem_we    = in_req && we_q;
    bus.mem_addr  = in_req ? addr_q  : '0;
    bus.mem_wdata = in_req ? wdata_q : '0;
    bus.mem_wstrb = in_req ? wstrb_q : '0;
    bus.if_gnt    = if_gnt_q;
    bus.ls_gnt    = ls_gnt_q;
    bus.if_rvalid = if_rvalid_q;
    bus.ls_rvalid = ls_rvalid_q;
    bus.if_rdata  = if_rdata_q;
    bus.ls_rdata  = ls_rdata_q;
`ifdef ARB_TIMEOUT_EN
    bus.bus_err   = bus_err_q;
`else
    bus.bus_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, writes, arbitration, starvation, reset abort.
// The watchdog scenario is included when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic rd_pend;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters must hold req until they see their grant.
  assert property (@(posedge clk) disable iff (rst)
    (!bus.if_req && $past(bus.if_req)) |-> bus.if_gnt)
    else $error("FAIL if_req_protocol: if_req dropped without if_gnt");
  assert property (@(posedge clk) disable iff (rst)
    (!bus.ls_req && $past(bus.ls_req)) |-> bus.ls_gnt)
    else $error("FAIL ls_req_protocol: ls_req dropped without ls_gnt");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple bus responder: accept immediately, return read data one cycle later.
  task automatic serve();
    bus.mem_rvalid = rd_pend;
    bus.mem_rdata  = 64'h5555;
    rd_pend        = bus.mem_req && !bus.mem_we;
    bus.mem_ready  = bus.mem_req;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit exp_is_ls [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int g;

    rst            = 1'b1;
    rd_pend        = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_wstrb   = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_if_gnt",    bus.if_gnt,    0);
    check("rst_ls_gnt",    bus.ls_gnt,    0);
    check("rst_if_rvalid", bus.if_rvalid, 0);
    check("rst_ls_rvalid", bus.ls_rvalid, 0);
    check("rst_if_rdata",  bus.if_rdata,  0);
    check("rst_ls_rdata",  bus.ls_rdata,  0);
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_bus_err",   bus.bus_err,   0);

    // IF read, minimum latency
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_0000;
    tick();
    check("rd_if_gnt",   bus.if_gnt,   1);
    check("rd_ls_gnt",   bus.ls_gnt,   0);
    check("rd_mem_req",  bus.mem_req,  1);
    check("rd_mem_we",   bus.mem_we,   0);
    check("rd_mem_addr", bus.mem_addr, 64'h8000_0000);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    check("rd_gnt_pulse", bus.if_gnt,  0);
    check("rd_req_drop",  bus.mem_req, 0);
    check("rd_no_early",  bus.if_rvalid, 0);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h13;
    tick();
    check("rd_if_rvalid", bus.if_rvalid, 1);
    check("rd_if_rdata",  bus.if_rdata,  64'h13);
    check("rd_ls_rvalid", bus.ls_rvalid, 0);
    check("rd_ls_rdata",  bus.ls_rdata,  0);
    bus.mem_rvalid = 1'b0;
    tick();
    check("rd_rvalid_pulse", bus.if_rvalid, 0);
    check("rd_rdata_hold",   bus.if_rdata,  64'h13);

    // Stray mem_rvalid while idle is ignored
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hFF;
    tick();
    bus.mem_rvalid = 1'b0;
    check("stray_if_rvalid", bus.if_rvalid, 0);
    check("stray_ls_rvalid", bus.ls_rvalid, 0);
    check("stray_if_rdata",  bus.if_rdata,  64'h13);
    check("stray_mem_req",   bus.mem_req,   0);

    // Simultaneous requests: LS first, IF on the back-to-back arbitration
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_0100;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h8000_1000;
    tick();
    check("both_ls_gnt",   bus.ls_gnt,   1);
    check("both_if_gnt",   bus.if_gnt,   0);
    check("both_mem_addr", bus.mem_addr, 64'h8000_1000);
    bus.ls_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h1111;
    tick();
    check("both_ls_rvalid", bus.ls_rvalid, 1);
    check("both_ls_rdata",  bus.ls_rdata,  64'h1111);
    check("both_if_rdata",  bus.if_rdata,  64'h13);
    check("both_if_wait",   bus.if_rvalid, 0);
    bus.mem_rvalid = 1'b0;
    tick();
    check("b2b_if_gnt",   bus.if_gnt,   1);
    check("b2b_mem_addr", bus.mem_addr, 64'h8000_0100);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h2222;
    tick();
    check("b2b_if_rvalid", bus.if_rvalid, 1);
    check("b2b_if_rdata",  bus.if_rdata,  64'h2222);
    check("b2b_ls_rdata",  bus.ls_rdata,  64'h1111);
    bus.mem_rvalid = 1'b0;
    tick();

    // LS write with mem_ready three cycles late
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 64'h8000_2000;
    bus.ls_wdata = 64'hDEAD_BEEF;
    bus.ls_wstrb = 8'h0F;
    tick();
    check("wr_ls_gnt",    bus.ls_gnt,    1);
    check("wr_mem_we",    bus.mem_we,    1);
    check("wr_mem_wstrb", bus.mem_wstrb, 8'h0F);
    bus.ls_req   = 1'b0;
    bus.ls_addr  = 64'h0BAD;
    bus.ls_wdata = 64'h0BAD;
    bus.ls_wstrb = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wr_hold%0d_req", i),   bus.mem_req,   1);
      check($sformatf("wr_hold%0d_addr", i),  bus.mem_addr,  64'h8000_2000);
      check($sformatf("wr_hold%0d_wdata", i), bus.mem_wdata, 64'hDEAD_BEEF);
      check($sformatf("wr_hold%0d_wstrb", i), bus.mem_wstrb, 8'h0F);
      check($sformatf("wr_hold%0d_ack", i),   bus.ls_rvalid, 0);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("wr_ack",      bus.ls_rvalid, 1);
    check("wr_ack_data", bus.ls_rdata,  0);
    check("wr_req_drop", bus.mem_req,   0);
    check("wr_if_quiet", bus.if_rvalid, 0);
    tick();
    check("wr_ack_pulse", bus.ls_rvalid, 0);

    // Starvation bound: 4 LS grants then 1 IF grant, repeating
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h8000_3000;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 64'h8000_4000;
    bus.ls_wdata = 64'h1;
    bus.ls_wstrb = 8'hFF;
    rd_pend      = 1'b0;
    g            = 0;
    for (int c = 0; c < 200 && g < 11; c++) begin
      tick();
      if (bus.if_gnt || bus.ls_gnt) begin
        check($sformatf("starve_g%0d_is_ls", g), bus.ls_gnt, exp_is_ls[g]);
        if (g == 9)  bus.if_req = 1'b0;
        if (g == 10) bus.ls_req = 1'b0;
        g++;
      end
      serve();
    end
    check("starve_grants", g, 11);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    repeat (4) begin
      tick();
      serve();
    end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.ls_we      = 1'b0;
    tick();
    check("starve_idle", bus.mem_req, 0);

    // Reset during RESP, late mem_rvalid ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_5000;
    tick();
    check("rstm_if_gnt", bus.if_gnt, 1);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_mem_req",  bus.mem_req,  0);
    check("rstm_if_rdata", bus.if_rdata, 0);
    check("rstm_ls_rdata", bus.ls_rdata, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hABC;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rstm_if_rvalid", bus.if_rvalid, 0);
    check("rstm_ls_rvalid", bus.ls_rvalid, 0);
    check("rstm_if_rdata2", bus.if_rdata,  0);
    check("rstm_mem_req2",  bus.mem_req,   0);
    check("rstm_gnts",      {bus.if_gnt, bus.ls_gnt}, 0);
    check("rstm_bus_err",   bus.bus_err,   0);
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h40;
    tick();
    check("rstm_idle_gnt", bus.ls_gnt, 1);
    bus.ls_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h77;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rstm_ls_rvalid2", bus.ls_rvalid, 1);
    check("rstm_ls_rdata2",  bus.ls_rdata,  64'h77);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: mem_ready never comes
    begin
      int n_hi;
      bus.if_req  = 1'b1;
      bus.if_addr = 64'h8000_6000;
      tick();
      check("wd_if_gnt", bus.if_gnt, 1);
      bus.if_req = 1'b0;
      n_hi = bus.mem_req ? 1 : 0;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (bus.mem_req) n_hi++;
        else break;
      end
      check("wd_req_cycles", n_hi, 255);
      check("wd_req_drop",   bus.mem_req,   0);
      check("wd_no_early",   bus.if_rvalid, 0);
      tick();
      check("wd_if_rvalid", bus.if_rvalid, 1);
      check("wd_bus_err",   bus.bus_err,   1);
      check("wd_if_rdata",  bus.if_rdata,  0);
      check("wd_ls_rvalid", bus.ls_rvalid, 0);
      tick();
      check("wd_err_pulse", bus.bus_err, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
